// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the single register-file write port.
// Port 0 (WB) has fixed priority; a bounded-wait guard forces a port-1 (MAC) grant.
module regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_valid,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data,
    output logic              p0_ready,
    input  logic              p1_valid,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    output logic              p1_ready,
    output logic              write_enable,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              grant_src,
    output logic [3:0]        starve_cnt
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    // Returns {grant_p1, grant_p0}; a starved port 1 overrides port 0.
    function automatic logic [1:0] arbitrate(input logic v0, input logic v1, input logic starved);
        logic [1:0] g;
        if (v1 && starved) begin
            g = 2'b10;
        end else if (v0) begin
            g = 2'b01;
        end else if (v1) begin
            g = 2'b10;
        end else begin
            g = 2'b00;
        end
        return g;
    endfunction

    logic [1:0]        grant_s;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              src_q, src_d;

    // Grant decision; no grant is issued while reset is held.
    always_comb begin
        grant_s = 2'b00;
        if (reset) begin
            grant_s = 2'b00;
        end else begin
            grant_s = arbitrate(p0_valid, p1_valid, starve_cnt_q >= MAX_WAIT_C);
        end
    end

    assign p0_ready = grant_s[0];
    assign p1_ready = grant_s[1];

    // Port-1 wait counter: clears on grant or idle, saturates at MAX_WAIT.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!p1_valid || grant_s[1]) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < MAX_WAIT_C) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Next write-port value; writes to x0 latch addr/data but keep enable low.
    always_comb begin
        we_d   = 1'b0;
        addr_d = {ADDR_W{1'b0}};
        data_d = {DATA_W{1'b0}};
        src_d  = 1'b0;
        case (grant_s)
            2'b01: begin
                we_d   = (p0_addr != {ADDR_W{1'b0}});
                addr_d = p0_addr;
                data_d = p0_data;
                src_d  = 1'b0;
            end
            2'b10: begin
                we_d   = (p1_addr != {ADDR_W{1'b0}});
                addr_d = p1_addr;
                data_d = p1_data;
                src_d  = 1'b1;
            end
            default: begin
                we_d   = 1'b0;
                addr_d = {ADDR_W{1'b0}};
                data_d = {DATA_W{1'b0}};
                src_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any write in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            data_q       <= {DATA_W{1'b0}};
            src_q        <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            src_q        <= src_d;
        end
    end

    assign write_enable = we_q;
    assign w_addr       = addr_q;
    assign w_data       = data_q;
    assign grant_src    = src_q;
    assign starve_cnt   = starve_cnt_q;

endmodule
